// File: rtl/nasti_burst_arbiter_if.sv
// Response-channel arbitration bundle: per-port valid/last in, upstream ready
// in, grant / mux select / gated readies / burst status out.
interface nasti_burst_arbiter_if #(
    parameter int N         = 8,
    parameter int CNT_WIDTH = 8
);
    localparam int SW = (N > 1) ? $clog2(N) : 1;

    logic                 enable;
    logic [N-1:0]         req;
    logic [N-1:0]         last;
    logic                 out_ready;
    logic [N-1:0]         gnt;
    logic [SW-1:0]        sel;
    logic                 out_valid;
    logic [N-1:0]         port_ready;
    logic                 locked;
    logic [CNT_WIDTH-1:0] beat_cnt;

    // Arbiter side: consumes requests, produces grant and status.
    modport master (
        input  enable, req, last, out_ready,
        output gnt, sel, out_valid, port_ready, locked, beat_cnt
    );

    // Requester / upstream side: the mirror image.
    modport slave (
        output enable, req, last, out_ready,
        input  gnt, sel, out_valid, port_ready, locked, beat_cnt
    );
endinterface

// File: rtl/nasti_burst_arbiter.sv
// Round-robin, burst-locking arbiter for one shared NASTI R/B channel.
// IDLE grants combinationally to the first eligible port at or after ptr;
// a non-last handshake locks that port until its last beat handshakes.
module nasti_burst_arbiter #(
    parameter int       N         = 8,
    parameter logic [7:0] PORT_EN = 8'hFF,
    parameter bit       LITE_MODE = 1'b0,
    parameter int       CNT_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    nasti_burst_arbiter_if.master   bus
);
    localparam int SW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {IDLE, BURST} state_t;

    state_t               state, state_n;
    logic [SW-1:0]        ptr, ptr_n, lock_port, lock_n, win, sel_c;
    logic [CNT_WIDTH-1:0] cnt, cnt_n;
    logic [N-1:0]         elig, gnt_c;
    logic                 rst_q, blocked, found, ov, hs, last_sel;
    int                   idx;

    assign elig    = bus.req & PORT_EN[N-1:0];
    // Grants are suppressed while rst is high and for one cycle after it.
    assign blocked = rst | rst_q;

    // Circular priority search starting at ptr; wraps explicitly at N.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!found && elig[idx]) begin
                found = 1'b1;
                win   = SW'(idx);
            end
        end
    end

    // Grant selection, handshake detection and next-state/counter update.
    always_comb begin
        state_n  = state;
        ptr_n    = ptr;
        lock_n   = lock_port;
        cnt_n    = cnt;
        gnt_c    = '0;
        sel_c    = '0;
        if (!blocked) begin
            if (state == BURST) begin
                gnt_c[lock_port] = 1'b1;
                sel_c            = lock_port;
            end else if (bus.enable && found) begin
                gnt_c[win] = 1'b1;
                sel_c      = win;
            end
        end
        ov       = |(gnt_c & bus.req);
        hs       = ov & bus.out_ready;
        last_sel = bus.last[sel_c] | LITE_MODE;
        if (hs) begin
            if (last_sel) begin
                // Just-served port drops to lowest priority.
                state_n = IDLE;
                ptr_n   = (sel_c == SW'(N - 1)) ? '0 : sel_c + 1'b1;
                cnt_n   = '0;
            end else if (state == IDLE) begin
                state_n = BURST;
                lock_n  = sel_c;
                cnt_n   = CNT_WIDTH'(1);
            end else if (cnt != '1) begin
                cnt_n = cnt + 1'b1;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            lock_port <= '0;
            cnt       <= '0;
            rst_q     <= 1'b1;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            lock_port <= lock_n;
            cnt       <= cnt_n;
            rst_q     <= 1'b0;
        end
    end

    assign bus.gnt        = gnt_c;
    assign bus.sel        = sel_c;
    assign bus.out_valid  = ov;
    assign bus.port_ready = gnt_c & {N{bus.out_ready}};
    assign bus.locked     = (state == BURST);
    assign bus.beat_cnt   = cnt;
endmodule

// File: tb/tb_nasti_burst_arbiter.sv
// Scoreboard bench: expected outputs are queued as each cycle's stimulus is
// driven, then popped and compared against the DUT on the falling edge.
module tb_nasti_burst_arbiter;
    logic clk, rst;
    int   vectors = 0;
    int   miscompares = 0;

    typedef struct packed {
        logic [7:0] gnt;
        logic       ov;
        logic [7:0] pr;
        logic       lk;
        logic [7:0] cnt;
    } obs_t;

    obs_t q[$];

    nasti_burst_arbiter_if #(.N(8), .CNT_WIDTH(8)) m_if ();
    nasti_burst_arbiter_if #(.N(8), .CNT_WIDTH(8)) e_if ();
    nasti_burst_arbiter_if #(.N(8), .CNT_WIDTH(8)) l_if ();

    nasti_burst_arbiter #(.N(8), .PORT_EN(8'hFF), .LITE_MODE(1'b0), .CNT_WIDTH(8))
        dut_m (.clk(clk), .rst(rst), .bus(m_if));
    nasti_burst_arbiter #(.N(8), .PORT_EN(8'h0F), .LITE_MODE(1'b0), .CNT_WIDTH(8))
        dut_e (.clk(clk), .rst(rst), .bus(e_if));
    nasti_burst_arbiter #(.N(8), .PORT_EN(8'hFF), .LITE_MODE(1'b1), .CNT_WIDTH(8))
        dut_l (.clk(clk), .rst(rst), .bus(l_if));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t mk(input logic [7:0] g, input logic v, input logic rdy,
                                input logic lk, input logic [7:0] c);
        obs_t o;
        o.gnt = g;
        o.ov  = v;
        o.pr  = rdy ? g : 8'h00;
        o.lk  = lk;
        o.cnt = c;
        return o;
    endfunction

    // Apply one cycle of stimulus to the selected DUT just after the rising edge.
    task automatic drive(input int which, input logic r, input logic [7:0] rq,
                         input logic [7:0] ls, input logic rdy, input logic en);
        @(posedge clk);
        #1;
        rst = r;
        case (which)
            0: begin m_if.req = rq; m_if.last = ls; m_if.out_ready = rdy; m_if.enable = en; end
            1: begin e_if.req = rq; e_if.last = ls; e_if.out_ready = rdy; e_if.enable = en; end
            default: begin l_if.req = rq; l_if.last = ls; l_if.out_ready = rdy; l_if.enable = en; end
        endcase
    endtask

    task automatic do_reset();
        drive(0, 1'b1, 8'h00, 8'hFF, 1'b1, 1'b1);
        drive(0, 1'b0, 8'h00, 8'hFF, 1'b1, 1'b1);
    endtask

    task automatic test_reset();
        logic       r  [7] = '{1, 0, 0, 0, 1, 0, 0};
        logic [7:0] rq [7] = '{8'h00, 8'h01, 8'h01, 8'h10, 8'h10, 8'h10, 8'h00};
        logic [7:0] ls [7] = '{8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'hFF};
        logic [7:0] g  [7] = '{8'h00, 8'h00, 8'h01, 8'h10, 8'h00, 8'h00, 8'h00};
        logic       v  [7] = '{0, 0, 1, 1, 0, 0, 0};
        logic       lk [7] = '{0, 0, 0, 0, 1, 0, 0};
        logic [7:0] c  [7] = '{0, 0, 0, 0, 1, 0, 0};
        obs_t got, exp;
        for (int i = 0; i < 7; i++) begin
            drive(0, r[i], rq[i], ls[i], 1'b1, 1'b1);
            q.push_back(mk(g[i], v[i], 1'b1, lk[i], c[i]));
            @(negedge clk);
            got = {m_if.gnt, m_if.out_valid, m_if.port_ready, m_if.locked, m_if.beat_cnt};
            exp = q.pop_front();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL reset step %0d: got %h need %h", i, got, exp);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] rq, g;
        obs_t got, exp;
        for (int i = 0; i < 14; i++) begin
            rq = (i < 4) ? 8'h81 : 8'hFF;
            g  = (i < 4) ? ((i % 2 == 0) ? 8'h01 : 8'h80) : (8'h01 << ((i - 4) % 8));
            drive(0, 1'b0, rq, 8'hFF, 1'b1, 1'b1);
            q.push_back(mk(g, 1'b1, 1'b1, 1'b0, 8'h00));
            @(negedge clk);
            got = {m_if.gnt, m_if.out_valid, m_if.port_ready, m_if.locked, m_if.beat_cnt};
            exp = q.pop_front();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL round_robin step %0d: got %h need %h", i, got, exp);
            end
        end
    endtask

    task automatic test_burst();
        logic [7:0] rq [6] = '{8'h24, 8'h24, 8'h24, 8'h24, 8'h20, 8'h00};
        logic [7:0] ls [6] = '{8'h00, 8'h00, 8'h00, 8'h04, 8'h20, 8'hFF};
        logic [7:0] g  [6] = '{8'h04, 8'h04, 8'h04, 8'h04, 8'h20, 8'h00};
        logic       v  [6] = '{1, 1, 1, 1, 1, 0};
        logic       lk [6] = '{0, 1, 1, 1, 0, 0};
        logic [7:0] c  [6] = '{0, 1, 2, 3, 0, 0};
        obs_t got, exp;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(0, 1'b0, rq[i], ls[i], 1'b1, 1'b1);
            q.push_back(mk(g[i], v[i], 1'b1, lk[i], c[i]));
            @(negedge clk);
            got = {m_if.gnt, m_if.out_valid, m_if.port_ready, m_if.locked, m_if.beat_cnt};
            exp = q.pop_front();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL burst step %0d: got %h need %h", i, got, exp);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] rq [7] = '{8'h0A, 8'h0A, 8'h0A, 8'h0A, 8'h08, 8'h0A, 8'h08};
        logic [7:0] ls [7] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 8'h08};
        logic       rd [7] = '{1, 0, 1, 0, 1, 1, 1};
        logic [7:0] g  [7] = '{8'h02, 8'h02, 8'h02, 8'h02, 8'h02, 8'h02, 8'h08};
        logic       v  [7] = '{1, 1, 1, 1, 0, 1, 1};
        logic       lk [7] = '{0, 1, 1, 1, 1, 1, 0};
        logic [7:0] c  [7] = '{0, 1, 1, 2, 2, 2, 0};
        obs_t got, exp;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            drive(0, 1'b0, rq[i], ls[i], rd[i], 1'b1);
            q.push_back(mk(g[i], v[i], rd[i], lk[i], c[i]));
            @(negedge clk);
            got = {m_if.gnt, m_if.out_valid, m_if.port_ready, m_if.locked, m_if.beat_cnt};
            exp = q.pop_front();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL backpressure step %0d: got %h need %h", i, got, exp);
            end
        end
    endtask

    task automatic test_enable();
        logic       en [7] = '{0, 0, 1, 0, 0, 0, 1};
        logic [7:0] rq [7] = '{8'h01, 8'h01, 8'h08, 8'h09, 8'h09, 8'h09, 8'h09};
        logic [7:0] ls [7] = '{8'hFF, 8'hFF, 8'h00, 8'h00, 8'h08, 8'hFF, 8'hFF};
        logic [7:0] g  [7] = '{8'h00, 8'h00, 8'h08, 8'h08, 8'h08, 8'h00, 8'h01};
        logic       v  [7] = '{0, 0, 1, 1, 1, 0, 1};
        logic       lk [7] = '{0, 0, 0, 1, 1, 0, 0};
        logic [7:0] c  [7] = '{0, 0, 0, 1, 2, 0, 0};
        obs_t got, exp;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            drive(0, 1'b0, rq[i], ls[i], 1'b1, en[i]);
            q.push_back(mk(g[i], v[i], 1'b1, lk[i], c[i]));
            @(negedge clk);
            got = {m_if.gnt, m_if.out_valid, m_if.port_ready, m_if.locked, m_if.beat_cnt};
            exp = q.pop_front();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL enable step %0d: got %h need %h", i, got, exp);
            end
        end
    endtask

    task automatic test_port_en();
        logic [7:0] rq, g;
        obs_t got, exp;
        for (int i = 0; i < 7; i++) begin
            rq = (i < 6) ? 8'hF0 : 8'hF1;
            g  = (i < 6) ? 8'h00 : 8'h01;
            drive(1, 1'b0, rq, 8'hFF, 1'b1, 1'b1);
            q.push_back(mk(g, (i == 6), 1'b1, 1'b0, 8'h00));
            @(negedge clk);
            got = {e_if.gnt, e_if.out_valid, e_if.port_ready, e_if.locked, e_if.beat_cnt};
            exp = q.pop_front();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL port_en step %0d: got %h need %h", i, got, exp);
            end
        end
    endtask

    task automatic test_lite();
        logic       rd [6] = '{1, 1, 0, 1, 1, 1};
        logic [7:0] g  [6] = '{8'h01, 8'h02, 8'h01, 8'h01, 8'h02, 8'h01};
        obs_t got, exp;
        for (int i = 0; i < 6; i++) begin
            drive(2, 1'b0, 8'h03, 8'h00, rd[i], 1'b1);
            q.push_back(mk(g[i], 1'b1, rd[i], 1'b0, 8'h00));
            @(negedge clk);
            got = {l_if.gnt, l_if.out_valid, l_if.port_ready, l_if.locked, l_if.beat_cnt};
            exp = q.pop_front();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL lite step %0d: got %h need %h", i, got, exp);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        m_if.req = '0; m_if.last = '1; m_if.out_ready = 1'b1; m_if.enable = 1'b1;
        e_if.req = '0; e_if.last = '1; e_if.out_ready = 1'b1; e_if.enable = 1'b1;
        l_if.req = '0; l_if.last = '1; l_if.out_ready = 1'b1; l_if.enable = 1'b1;
        test_reset();
        test_round_robin();
        test_burst();
        test_backpressure();
        test_enable();
        test_port_en();
        test_lite();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/nasti_burst_arbiter.md
Name: nasti_burst_arbiter

Overview:
- Round-robin, burst-aware arbiter that shares one NASTI response channel (R or B) among N sources.
- Sits between the per-port response channels of a NASTI demux/crossbar and the single upstream master.
- Once a burst is granted, the grant is held until the last beat handshakes, so beats of different bursts never interleave.
- Provides the mux select, per-port ready gating, and simple burst/beat status.

Parameters:
N, 8, number of requesting ports (2..8)
PORT_EN, 8'hFF, per-port enable mask; a disabled port is never granted
LITE_MODE, 0, 1 = every beat is treated as last (no burst lock)
CNT_WIDTH, 8, width of the beat counter

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
enable  input  1  allows new grants; an open burst always completes
req  input  N  per-port valid (r_valid/b_valid of each slave-side port)
last  input  N  per-port last flag (r_last); tie to 1 for the B channel
out_ready  input  1  upstream ready (master.r_ready/b_ready)
gnt  output  N  one-hot grant (zero when nothing is granted)
sel  output  $clog2(N)  index of the granted port (0 when none)
out_valid  output  1  req[sel] qualified by grant
port_ready  output  N  out_ready AND gnt, per port
locked  output  1  burst in progress (state BURST)
beat_cnt  output  CNT_WIDTH  beats completed in the current burst

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, ptr=0, lock_port=0, beat_cnt=0. During rst and the following cycle, gnt, out_valid and port_ready are 0 (rst gates grants combinationally).
- Eligibility: elig = req & PORT_EN[N-1:0].
- Handshake: hs = out_valid & out_ready.
- Winner: first set bit of elig, searching circularly from ptr upward (ptr, ptr+1, ..., N-1, 0, ..., ptr-1).
- State IDLE:
  - If enable and elig != 0: gnt = onehot(winner) in the same cycle (zero-latency combinational grant); sel = winner.
  - Else gnt = 0.
  - If hs and (last[sel] or LITE_MODE): stay IDLE; ptr <= (sel+1) mod N; beat_cnt <= 0.
  - If hs and !last[sel] and !LITE_MODE: go to BURST; lock_port <= sel; beat_cnt <= 1.
  - No hs: nothing registered. The grant may move next cycle if req changes; sources must hold valid per NASTI rules.
- State BURST:
  - gnt = onehot(lock_port) regardless of enable or other requests; sel = lock_port.
  - out_valid = req[lock_port]. Bubbles (req low) keep the lock.
  - hs and !last: beat_cnt <= beat_cnt+1, saturating at all-ones.
  - hs and last: go to IDLE; ptr <= (lock_port+1) mod N; beat_cnt <= 0.
  - If the locked port drops out of PORT_EN, that is illegal because PORT_EN is static.
- Fairness: a port that has just completed gets lowest priority next time, so every eligible port is served within N bursts.
- Simultaneous events:
  - A last-beat handshake and a new request in the same cycle: the new grant takes effect the next cycle with the updated ptr. One idle arbitration cycle is not inserted; back-to-back bursts are allowed.
  - enable low: blocks only IDLE grants; a BURST continues to last.
- Reset mid-burst: returns to IDLE immediately with gnt=0. Any partial burst upstream is the system's responsibility.
- out_ready low: all outputs hold; no state change.
- N not a power of two: ptr wraps explicitly at N.
- Invariants:
  - gnt is one-hot or zero.
  - port_ready is a subset of gnt.
  - out_valid implies gnt != 0.

Test Plan:
- Reset then req=8'h00 -> gnt=0, out_valid=0, beat_cnt=0, locked=0. Assert rst for 1 cycle mid-stream -> gnt=0 in the rst cycle and the next cycle, state IDLE.
- req=8'h81, out_ready=1, last=1 on every beat, ptr=0 -> grants 0,7,0,7 on consecutive cycles. Then req=8'hFF continuously -> grants 0..7 in order, repeating.
- Port 2 starts a 4-beat burst (last on beat 4) while port 5 holds req from cycle 1 -> gnt=8'h04 for 4 handshakes, locked=1, beat_cnt 1,2,3. Next cycle gnt=8'h20, beat_cnt=0.
- Burst on port 1 with out_ready toggling 1,0,1,0 and a req[1] bubble mid-burst -> gnt stays 8'h02 throughout, beat_cnt increments only on handshake cycles, and no other port is granted.
- PORT_EN=8'h0F, req=8'hF0 -> gnt=0 forever. Then enable=0 in IDLE with req=8'h01 -> gnt=0. enable=0 during an open burst on port 3 -> burst completes to last.
- LITE_MODE=1, last=0, req=8'h03 -> alternating grants 0,1,0,1; locked never asserted.
